// File: rtl/iob_pwm_capture_pkg.sv
// Shared types and helpers for the PWM capture block.
//   state_t  : capture FSM encoding (IDLE, WAIT_RISE, MEASURE)
//   cnt_max(): all-ones saturation value for a counter of the given width
// Optional feature macro (used by the edge sub-module): IOB_PWM_CAPTURE_FILT_EN
package iob_pwm_capture_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/iob_pwm_capture_if.sv
// Control/result bundle of the PWM capture block.
//   en           : capture enable
//   clear_ovf    : one-cycle pulse clearing ovf_o
//   pwm_input    : asynchronous PWM waveform
//   period_o     : last measured period (clk cycles)
//   high_o       : last measured high time (clk cycles)
//   meas_valid_o : one-cycle strobe, new period_o/high_o
//   ovf_o        : sticky counter-saturation flag
// master = register file / stimulus side, slave = capture block.
interface iob_pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clear_ovf;
  logic             pwm_input;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             meas_valid_o;
  logic             ovf_o;

  modport master (
    output en, clear_ovf, pwm_input,
    input  period_o, high_o, meas_valid_o, ovf_o
  );

  modport slave (
    input  en, clear_ovf, pwm_input,
    output period_o, high_o, meas_valid_o, ovf_o
  );
endinterface

// File: rtl/iob_pwm_capture_edge.sv
// Input conditioning for the PWM capture block: synchroniser, optional glitch
// filter and edge register.
//   clk, rst  : clock, asynchronous active-high reset
//   pwm_input : asynchronous waveform
//   level     : conditioned level
//   rise/fall : one-cycle edge indications, never both high
// Optional feature macro: IOB_PWM_CAPTURE_FILT_EN. When defined, the level only
// follows the synchronised input after it has held a new value for FILT_LEN
// consecutive cycles; otherwise FILT_LEN is unused by the datapath.
module iob_pwm_capture_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_input,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   level_d;

  // NOTE: every flop is written with <= so all stages sample the pre-edge
  // values; blocking assignments here would collapse the chain to one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_input};
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef IOB_PWM_CAPTURE_FILT_EN
  localparam int FCW = $clog2(FILT_LEN + 1);

  logic [FCW-1:0] filt_cnt;
  logic           filt_q;

  // Counts consecutive cycles the input disagrees with the filtered level;
  // any agreement restarts the count, so short pulses never reach FILT_LEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b0;
      filt_cnt <= '0;
    end else if (sync_lvl == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
      filt_q   <= sync_lvl;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end

  assign level = filt_q;
`else
  assign level = sync_lvl;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

  assert property (@(posedge clk) (SYNC_STAGES >= 2) && (FILT_LEN >= 1));

endmodule

// File: rtl/iob_pwm_capture.sv
// PWM capture: measures clk cycles between consecutive rising edges (period)
// and from a rising edge to the following falling edge (high time).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : iob_pwm_capture_if.slave (en, clear_ovf, pwm_input in;
//              period_o, high_o, meas_valid_o, ovf_o out)
// The first rise after enable only aligns the counter. Each later rise
// publishes the completed period with a one-cycle meas_valid_o strobe.
// A counter reaching CNT_MAX without a rise sets the sticky ovf_o and
// re-aligns on the next rise. Input latency is constant and cancels out.
// Optional feature macro: IOB_PWM_CAPTURE_FILT_EN (glitch filter, see edge).
module iob_pwm_capture
  import iob_pwm_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input logic               clk,
  input logic               rst,
  iob_pwm_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_lat;
  logic             level;
  logic             rise;
  logic             fall;

  iob_pwm_capture_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_edge (
    .clk       (clk),
    .rst       (rst),
    .pwm_input (bus.pwm_input),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      high_lat         <= '0;
      bus.period_o     <= '0;
      bus.high_o       <= '0;
      bus.meas_valid_o <= 1'b0;
      bus.ovf_o        <= 1'b0;
    end else begin
      // NOTE: later non-blocking assignments to the same flop win, so the
      // default-low strobe and the clear below are overridden further down
      // by a new strobe or a new saturation in the same cycle.
      bus.meas_valid_o <= 1'b0;
      if (bus.clear_ovf) bus.ovf_o <= 1'b0;

      if (!bus.en) begin
        state    <= IDLE;
        cnt      <= '0;
        high_lat <= '0;
      end else begin
        case (state)
          IDLE: state <= WAIT_RISE;

          WAIT_RISE: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= MEASURE;
            end
          end

          MEASURE: begin
            if (rise) begin
              bus.period_o     <= cnt;
              bus.high_o       <= high_lat;
              bus.meas_valid_o <= 1'b1;
              cnt              <= CNT_W'(1);
            end else if (cnt == CNT_MAX) begin
              // Period too long to represent: flag it and re-align.
              bus.ovf_o <= 1'b1;
              cnt       <= '0;
              state     <= WAIT_RISE;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (fall) high_lat <= cnt;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(rise && fall));
  assert property (@(posedge clk) disable iff (rst) rise |-> level);
  assert property (@(posedge clk) disable iff (rst)
                   bus.meas_valid_o |=> !bus.meas_valid_o);

endmodule

// File: tb/tb_iob_pwm_capture.sv
// Self-checking bench for iob_pwm_capture (CNT_W=16, SYNC_STAGES=2, FILT_LEN=3).
// A timestamp model derives period/high/strobe/ovf from the driven waveform;
// directed sections pin the model with hand-computed values.
module tb_iob_pwm_capture;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;
`ifdef IOB_PWM_CAPTURE_FILT_EN
  localparam int LAT     = SYNC_STAGES + FILT_LEN; // input change -> acted-on edge
  localparam int LVL_OFS = SYNC_STAGES + 1;
`else
  localparam int LAT     = SYNC_STAGES;
  localparam int LVL_OFS = SYNC_STAGES;
`endif

  logic clk;
  logic rst;

  iob_pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  iob_pwm_capture #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_strobe = 0;
  int last_rise_cyc = 0;
  bit cmp_on = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  // Works on input samples and edge timestamps: a period is the distance
  // between two acted-on rises, the high time the distance rise -> fall.
  typedef enum int {M_OFF, M_ARMED, M_MEAS} mode_t;

  bit          xh[$];   // raw samples since reset, one per edge
  bit          lh[$];   // conditioned level per sample
  mode_t       mode;
  int          e;
  int          t_rise;
  int          t_fall;
  bit          m_rise;
  bit          m_fall;
  logic [15:0] m_period;
  logic [15:0] m_high;
  logic        m_valid;
  logic        m_ovf;

  function automatic bit x_at(input int j);
    return (j >= 0 && j < xh.size()) ? xh[j] : 1'b0;
  endfunction

  function automatic bit l_at(input int j);
    return (j >= 0 && j < lh.size()) ? lh[j] : 1'b0;
  endfunction

  // Conditioned level for sample j: with the filter a new value counts only
  // once the last FILT_LEN samples all agree on it.
  function automatic bit next_level(input int j);
`ifdef IOB_PWM_CAPTURE_FILT_EN
    for (int i = 1; i < FILT_LEN; i++)
      if (x_at(j - i) != x_at(j)) return l_at(j - 1);
`endif
    return x_at(j);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xh.delete();
      lh.delete();
      mode     = M_OFF;
      e        = 0;
      t_rise   = 0;
      t_fall   = 0;
      m_period = '0;
      m_high   = '0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      lh.push_back(1'b0);
      xh.push_back(bus.pwm_input);
      lh[e]  = next_level(e);
      m_rise = l_at(e - LVL_OFS) && !l_at(e - LVL_OFS - 1);
      m_fall = !l_at(e - LVL_OFS) && l_at(e - LVL_OFS - 1);
      m_valid = 1'b0;
      if (bus.clear_ovf) m_ovf = 1'b0;
      if (!bus.en) begin
        mode = M_OFF;
      end else begin
        case (mode)
          M_OFF:   mode = M_ARMED;
          M_ARMED: if (m_rise) begin mode = M_MEAS; t_rise = e; end
          M_MEAS: begin
            if (m_rise) begin
              m_period = 16'(e - t_rise);
              m_high   = 16'(t_fall - t_rise);
              m_valid  = 1'b1;
              t_rise   = e;
            end else if (e - t_rise == CNT_MAX) begin
              m_ovf = 1'b1;
              mode  = M_ARMED;
            end else if (m_fall) begin
              t_fall = e;
            end
          end
          default: mode = M_OFF;
        endcase
      end
      e++;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      check($sformatf("cycle %0d {period,high,valid,ovf}", cyc),
            {bus.period_o, bus.high_o, bus.meas_valid_o, bus.ovf_o},
            {m_period, m_high, m_valid, m_ovf});
      if (bus.meas_valid_o) n_strobe++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      if (v && !bus.pwm_input) last_rise_cyc = cyc;
      bus.pwm_input = v;
    end
  endtask

  task automatic pulse_train(input int p, input int h, input int n);
    repeat (n) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded 2000000 ns, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int ovf_cyc;
    bit found;

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.clear_ovf = 1'b0;
    bus.pwm_input = 1'b0;
    repeat (3) @(negedge clk);
    check("reset period_o", bus.period_o, 0);
    check("reset high_o", bus.high_o, 0);
    check("reset meas_valid_o", bus.meas_valid_o, 0);
    check("reset ovf_o", bus.ovf_o, 0);
    rst    = 1'b0;
    cmp_on = 1'b1;

    // 1: P=100/H=25, five periods -> four strobes, first rise only aligns.
    @(negedge clk) bus.en = 1'b1;
    drive(1'b0, 5);
    s0 = n_strobe;
    pulse_train(100, 25, 5);
    drive(1'b0, 20);
    check("p100 strobes", n_strobe - s0, 4);
    check("p100 period", bus.period_o, 100);
    check("p100 high", bus.high_o, 25);

`ifndef IOB_PWM_CAPTURE_FILT_EN
    // 2: minimum waveform P=2/H=1, then P=7/H=6.
    s0 = n_strobe;
    pulse_train(2, 1, 10);
    check("p2 period", bus.period_o, 2);
    check("p2 high", bus.high_o, 1);
    pulse_train(7, 6, 5);
    drive(1'b0, 10);
    check("p7 strobes", n_strobe - s0, 15);
    check("p7 period", bus.period_o, 7);
    check("p7 high", bus.high_o, 6);
`endif

    // 3: saturation after input stalls low, then clear and re-measure.
    pulse_train(50, 10, 3);
    found   = 1'b0;
    ovf_cyc = 0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk);
      if (bus.ovf_o) begin
        found   = 1'b1;
        ovf_cyc = cyc;
      end
    end
    check("ovf seen", found, 1);
    // Rise sampled one edge after its drive, acted on LAT edges later,
    // saturation CNT_MAX edges after that.
    check("ovf delay", ovf_cyc - last_rise_cyc, CNT_MAX + LAT + 1);
    check("ovf keeps period", bus.period_o, 50);
    check("ovf keeps high", bus.high_o, 10);
    @(negedge clk) bus.clear_ovf = 1'b1;
    @(negedge clk) bus.clear_ovf = 1'b0;
    check("ovf cleared", bus.ovf_o, 0);
    s0 = n_strobe;
    pulse_train(50, 10, 3);
    check("post-ovf strobes", n_strobe - s0, 2);
    check("post-ovf period", bus.period_o, 50);
    check("post-ovf high", bus.high_o, 10);

    // 4: enable dropped mid-period for 20 cycles.
    pulse_train(100, 30, 2);
    drive(1'b1, 30);
    drive(1'b0, 20);
    s0 = n_strobe;
    @(negedge clk) bus.en = 1'b0;
    drive(1'b0, 19);
    @(negedge clk) bus.en = 1'b1;
    drive(1'b0, 30);
    pulse_train(100, 35, 3);
    check("re-enable strobes", n_strobe - s0, 2);
    check("re-enable period", bus.period_o, 100);
    check("re-enable high", bus.high_o, 35);

    // 5: asynchronous reset in the middle of a measurement.
    drive(1'b1, 10);
    #2 rst = 1'b1;
    #1;
    check("async rst period_o", bus.period_o, 0);
    check("async rst high_o", bus.high_o, 0);
    check("async rst meas_valid_o", bus.meas_valid_o, 0);
    check("async rst ovf_o", bus.ovf_o, 0);
    bus.pwm_input = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = n_strobe;
    drive(1'b0, 10);
    pulse_train(60, 20, 3);
    check("after rst strobes", n_strobe - s0, 2);
    check("after rst period", bus.period_o, 60);
    check("after rst high", bus.high_o, 20);

    // 6: P=100/H=40 with a one-cycle glitch 20 cycles into the low phase.
    s0 = n_strobe;
    repeat (4) begin
      drive(1'b1, 40);
      drive(1'b0, 20);
      drive(1'b1, 1);
      drive(1'b0, 39);
    end
`ifdef IOB_PWM_CAPTURE_FILT_EN
    check("glitch strobes", n_strobe - s0, 4);
    check("glitch period", bus.period_o, 100);
    check("glitch high", bus.high_o, 40);
`else
    check("glitch strobes", n_strobe - s0, 8);
    check("glitch period", bus.period_o, 60);
    check("glitch high", bus.high_o, 40);
`endif

    drive(1'b0, 5);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/iob_pwm_capture.md
Name: iob_pwm_capture

Overview:
Measures an external PWM waveform. It is the receive-side counterpart of the team's PWM generator and is used in loopback tests and for sensor/servo feedback. The block synchronises the input, detects edges, and counts clk cycles between consecutive rising edges (period) and from a rising edge to the following falling edge (high time). Each completed period produces a one-cycle measurement strobe; the results are then read by the register file.

Parameters:
CNT_W, 16, width of period/high counters and result outputs
SYNC_STAGES, 2, flip-flops in input synchroniser (>=2)
FILT_LEN, 3, stable-cycles required by glitch filter (used only with optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  capture enable
pwm_input  in  1  asynchronous PWM waveform
clear_ovf  in  1  one-cycle pulse; clears ovf_o
period_o  out  CNT_W  last measured period, clk cycles
high_o  out  CNT_W  last measured high time, clk cycles
meas_valid_o  out  1  one-cycle strobe, new period_o/high_o
ovf_o  out  1  sticky counter-saturation flag

Behaviour:
- Reset (async, rst=1): period_o=0, high_o=0, meas_valid_o=0, ovf_o=0, cnt=0, high_lat=0, sync chain=0, state=IDLE.
- Input path: SYNC_STAGES flops, then one edge register. rise = s & ~s_d; fall = ~s & s_d. Detection latency is SYNC_STAGES+1 cycles. This latency is constant, so it cancels out of all measurements.
- FSM states: IDLE, WAIT_RISE, MEASURE.
- IDLE: while en=0, cnt held at 0. When en=1, go to WAIT_RISE.
- WAIT_RISE: no counting. On rise, set cnt<=1 and go to MEASURE. The first rise after enable is used only for alignment and produces no strobe.
- MEASURE: cnt<=cnt+1 each cycle.
  - On fall: high_lat<=cnt.
  - On rise: period_o<=cnt, high_o<=high_lat, meas_valid_o<=1 (visible the cycle after the rise is detected), cnt<=1.
  - Resulting values: for a waveform with period P and high time H, period_o=P and high_o=H.
- Saturation: in MEASURE, if cnt==2^CNT_W-1 and no rise this cycle, then ovf_o<=1, state<=WAIT_RISE, and no strobe is issued. Results hold their previous values.
- en=0 in any state: go to IDLE next cycle, clear cnt and high_lat, suppress any strobe. period_o/high_o hold.
- clear_ovf: clears ovf_o. If it coincides with a new saturation, the set wins.
- Rise and fall cannot occur in the same cycle. Minimum measurable waveform is P=2, H=1.
- meas_valid_o is never high for two consecutive cycles.

Optional Feature:
- Macro: IOB_PWM_CAPTURE_FILT_EN.
- Defined: a glitch filter sits between the synchroniser and the edge register. The filtered level changes only after the synchronised input has held the new level for FILT_LEN consecutive cycles. This adds a constant FILT_LEN-cycle latency, and pulses shorter than FILT_LEN cycles are discarded.
- Undefined: no filter; the synchroniser output feeds the edge register directly, and FILT_LEN is ignored.

Decomposition:
- Package iob_pwm_capture_pkg: FSM state encoding localparams (IDLE, WAIT_RISE, MEASURE), CNT_MAX function of CNT_W.
- Sub-module iob_pwm_capture_edge: synchroniser, optional filter and edge register. Outputs are level, rise and fall.
- Top module: FSM, counters and result registers.

Test Plan:
- CNT_W=16, en=1, P=100/H=25 square wave for 5 periods -> meas_valid_o pulses every 100 cycles starting at the second rise; period_o=100, high_o=25; no strobe at the first rise.
- P=2/H=1 continuous -> period_o=2, high_o=1, strobe every 2 cycles; then switch to P=7/H=6 -> first strobe after the switch shows 7/6.
- 3 periods of P=50/H=10, then input held low -> ovf_o=1 exactly 65535 cycles after the last rise, no strobe, results stay 50/10. Pulse clear_ovf -> ovf_o=0. Next two rises -> valid 50/10 again.
- en dropped mid-period (P=100) for 20 cycles then raised -> no strobe from the interrupted period; the first strobe comes at the second rise after re-enable and equals 100/H.
- rst pulsed asynchronously mid-MEASURE -> all outputs 0 immediately, without waiting for a clk edge. After release with en=1, the block behaves as from power-up.
- FILT_EN defined, FILT_LEN=3, P=100/H=40 with a 1-cycle high glitch inside the low phase -> period_o=100, high_o=40. Without FILT_EN, the same stimulus produces an extra short-period strobe.
